// File: rtl/escala_pkg.sv
// Shared definitions for the scaling datapath (zoom-in replicator and 2x decimator).
//   DATA_W   : pixel width in bits
//   MAX_LARG : maximum input row width, sets the line-buffer depth
//   COORD_W  : width of image dimensions and x/y coordinates
//   estado_t : FSM state encoding shared by both scalers
package escala_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_LARG = 640;
    localparam int unsigned COORD_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LINHA_A = 2'd1,
        S_LINHA_B = 2'd2,
        S_FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/replicacao_zoom_in_if.sv
// Control and pixel-stream bundle of the 2x zoom-in replicator.
//   master : frame source / pixel producer side (drives start, sizes, pixel_in)
//   slave  : the replicator (drives ready, pixel_out, done, busy)
interface replicacao_zoom_in_if #(
    parameter int unsigned DATA_W = escala_pkg::DATA_W
);
    import escala_pkg::*;

    logic               start;
    logic [COORD_W-1:0] largura_in;
    logic [COORD_W-1:0] altura_in;
    logic [DATA_W-1:0]  pixel_in;
    logic               pixel_in_valid;
    logic               pixel_in_ready;
    logic [DATA_W-1:0]  pixel_out;
    logic               pixel_out_valid;
    logic               processing_done;
    logic               busy;

    modport master (
        output start, largura_in, altura_in, pixel_in, pixel_in_valid,
        input  pixel_in_ready, pixel_out, pixel_out_valid, processing_done, busy
    );

    modport slave (
        input  start, largura_in, altura_in, pixel_in, pixel_in_valid,
        output pixel_in_ready, pixel_out, pixel_out_valid, processing_done, busy
    );

endinterface

// File: rtl/buffer_linha.sv
// Single-port synchronous line buffer holding one input row.
//   clk_i   : clock
//   we_i    : write enable (a write cycle does not update dado_o)
//   end_i   : address
//   dado_i  : write data
//   dado_o  : read data, one cycle after the address
module buffer_linha #(
    parameter int unsigned PROF   = escala_pkg::MAX_LARG,
    parameter int unsigned LARG_D = escala_pkg::DATA_W,
    parameter int unsigned END_W  = escala_pkg::COORD_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [END_W-1:0]  end_i,
    input  logic [LARG_D-1:0] dado_i,
    output logic [LARG_D-1:0] dado_o
);
    logic [LARG_D-1:0] mem_q [PROF];
    logic [LARG_D-1:0] dado_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[end_i] <= dado_i;
        end else begin
            dado_q <= mem_q[end_i];
        end
    end

    assign dado_o = dado_q;

endmodule

// File: rtl/replicacao_zoom_in.sv
// 2x nearest-neighbour upscaler: every input pixel is emitted twice (row A),
// then the whole row is replayed from the line buffer (row B).
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : start/size inputs, pixel_in valid/ready stream, pixel_out valid
//           stream (no backpressure), processing_done pulse, busy
module replicacao_zoom_in #(
    parameter int unsigned MAX_LARG = escala_pkg::MAX_LARG,
    parameter int unsigned DATA_W   = escala_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    replicacao_zoom_in_if.slave  bus
);
    import escala_pkg::*;

    localparam logic [COORD_W-1:0] MAX_W = COORD_W'(MAX_LARG);
    localparam logic [COORD_W-1:0] UM    = COORD_W'(1);

    estado_t            estado_q, estado_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic               fase_q, fase_d;
    logic [DATA_W-1:0]  pix_q, pix_d;
    logic               valid_q, valid_d, done_q, done_d;

    logic               buf_we;
    logic [COORD_W-1:0] buf_end;
    logic [DATA_W-1:0]  buf_rd;
    logic               ready;
    logic               ultimo_x, ultimo_y;
    logic [COORD_W-1:0] larg_sat;

    assign ultimo_x = (x_q == w_q - UM);
    assign ultimo_y = (y_q == h_q - UM);
    assign larg_sat = (bus.largura_in > MAX_W) ? MAX_W : bus.largura_in;

    buffer_linha #(
        .PROF   (MAX_LARG),
        .LARG_D (DATA_W),
        .END_W  (COORD_W)
    ) u_buffer (
        .clk_i  (clk),
        .we_i   (buf_we),
        .end_i  (buf_end),
        .dado_i (bus.pixel_in),
        .dado_o (buf_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            fase_q   <= 1'b0;
            pix_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            fase_q   <= fase_d;
            pix_q    <= pix_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        fase_d   = fase_q;
        pix_d    = pix_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        buf_we   = 1'b0;
        buf_end  = x_q;
        ready    = 1'b0;

        case (estado_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_d    = larg_sat;
                    h_d    = bus.altura_in;
                    x_d    = '0;
                    y_d    = '0;
                    fase_d = 1'b0;
                    if (bus.largura_in == '0 || bus.altura_in == '0) begin
                        estado_d = S_FIM;
                    end else begin
                        estado_d = S_LINHA_A;
                    end
                end
            end

            S_LINHA_A: begin
                if (!fase_q) begin
                    ready = 1'b1;
                    if (bus.pixel_in_valid) begin
                        buf_we  = 1'b1;
                        pix_d   = bus.pixel_in;
                        valid_d = 1'b1;
                        fase_d  = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                    fase_d  = 1'b0;
                    if (ultimo_x) begin
                        // Prefetch buf[0] so row B starts with no bubble.
                        buf_end  = '0;
                        x_d      = '0;
                        estado_d = S_LINHA_B;
                    end else begin
                        x_d = x_q + UM;
                    end
                end
            end

            S_LINHA_B: begin
                valid_d = 1'b1;
                fase_d  = ~fase_q;
                // Address always runs one pixel ahead of the output register.
                buf_end = ultimo_x ? '0 : x_q + UM;
                if (!fase_q) begin
                    pix_d = buf_rd;
                end else if (ultimo_x) begin
                    x_d = '0;
                    if (ultimo_y) begin
                        estado_d = S_FIM;
                    end else begin
                        y_d      = y_q + UM;
                        estado_d = S_LINHA_A;
                    end
                end else begin
                    x_d = x_q + UM;
                end
            end

            S_FIM: begin
                done_d   = 1'b1;
                estado_d = S_IDLE;
            end

            default: estado_d = S_IDLE;
        endcase
    end

    assign bus.pixel_in_ready  = ready;
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_out_valid = valid_q;
    assign bus.processing_done = done_q;
    assign bus.busy            = (estado_q != S_IDLE);

endmodule

// File: tb/tb_replicacao_zoom_in.sv
// Scoreboard bench for the 2x zoom-in replicator: stimulus pushes expected
// output pixels into a queue, a negedge monitor pops and compares them.
module tb_replicacao_zoom_in;

    logic clk;
    logic reset;

    replicacao_zoom_in_if #(.DATA_W(8)) bus ();

    replicacao_zoom_in #(
        .MAX_LARG (640),
        .DATA_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         exp_q[$];
    logic [7:0] in_arr[$];
    int out_cnt, xfer_cnt, ready_cnt, done_cnt, overflow;
    int done_cyc, last_valid_cyc, run_len, max_run, start_cyc;

    int exp_basic[16] = '{10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40};
    int exp_gaps[12]  = '{1,1,2,2,3,3,1,1,2,2,3,3};
    int exp_rst[16]   = '{11,11,12,12,13,13,14,14,11,11,12,12,13,13,14,14};
    int exp_busy[16]  = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};

    task automatic chk(input string nome, input int got, input int expv);
        n_total++;
        if (got == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nome, got, got, expv, expv, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pixel_in_ready) ready_cnt++;
            if (bus.pixel_in_ready && bus.pixel_in_valid) xfer_cnt++;
            if (bus.pixel_out_valid) begin
                out_cnt++;
                run_len = (last_valid_cyc == cyc - 1) ? run_len + 1 : 1;
                if (run_len > max_run) max_run = run_len;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) overflow++;
                else chk("pixel_out", int'(bus.pixel_out), exp_q.pop_front());
            end
            if (bus.processing_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        exp_q.delete();
        in_arr.delete();
        out_cnt = 0; xfer_cnt = 0; ready_cnt = 0; done_cnt = 0; overflow = 0;
        done_cyc = -100; last_valid_cyc = -100; run_len = 0; max_run = 0;
    endtask

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        bus.largura_in = 10'(w);
        bus.altura_in  = 10'(h);
        bus.start      = 1'b1;
        start_cyc      = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drive(input bit gaps, input int budget);
        int idx;
        int c;
        bit v;
        bit t;
        idx = 0;
        c   = 0;
        while (idx < in_arr.size() && c < budget) begin
            v = gaps ? (c % 3 == 0) : 1'b1;
            bus.pixel_in_valid = v;
            bus.pixel_in       = in_arr[idx];
            @(negedge clk);
            t = v && bus.pixel_in_ready;
            @(posedge clk); #1;
            if (t) idx++;
            c++;
        end
        bus.pixel_in_valid = 1'b0;
        chk("inputs consumed", idx, in_arr.size());
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string nome, input int exp_out, input int exp_xfer);
        chk({nome, " out_count"}, out_cnt, exp_out);
        chk({nome, " xfer_count"}, xfer_cnt, exp_xfer);
        chk({nome, " done_pulses"}, done_cnt, 1);
        chk({nome, " leftover_expected"}, exp_q.size(), 0);
        chk({nome, " extra_pixels"}, overflow, 0);
        if (exp_out > 0) chk({nome, " done_after_last"}, done_cyc - last_valid_cyc, 1);
        chk({nome, " busy_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.largura_in     = '0;
        bus.altura_in      = '0;
        bus.pixel_in       = '0;
        bus.pixel_in_valid = 1'b0;
        clear_stats();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", int'({bus.pixel_out, bus.pixel_out_valid, bus.processing_done,
                                   bus.pixel_in_ready, bus.busy}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic 2x2
        clear_stats();
        in_arr = '{8'd10, 8'd20, 8'd30, 8'd40};
        foreach (exp_basic[i]) exp_q.push_back(exp_basic[i]);
        start_frame(2, 2);
        drive(1'b0, 100);
        wait_done(100);
        end_checks("basic2x2", 16, 4);
        chk("basic2x2 ready_cycles", ready_cnt, 4);

        // Input gaps
        clear_stats();
        in_arr = '{8'd1, 8'd2, 8'd3};
        foreach (exp_gaps[i]) exp_q.push_back(exp_gaps[i]);
        start_frame(3, 1);
        drive(1'b1, 100);
        wait_done(100);
        end_checks("gaps", 12, 3);
        chk("gaps longest_valid_run", max_run, 8);

        // W=0, H=5
        clear_stats();
        start_frame(0, 5);
        bus.pixel_in_valid = 1'b1;
        wait_done(50);
        bus.pixel_in_valid = 1'b0;
        end_checks("w0", 0, 0);
        chk("w0 ready_cycles", ready_cnt, 0);
        chk("w0 done_latency", done_cyc - start_cyc, 2);

        // W=1, H=1
        clear_stats();
        in_arr = '{8'hAB};
        repeat (4) exp_q.push_back(8'hAB);
        start_frame(1, 1);
        drive(1'b0, 20);
        wait_done(50);
        end_checks("w1h1", 4, 1);

        // Saturation: W=700 clipped to 640
        clear_stats();
        for (int i = 0; i < 640; i++) in_arr.push_back(8'(i) ^ 8'h5A);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 640; i++) begin
                exp_q.push_back(int'(8'(i) ^ 8'h5A));
                exp_q.push_back(int'(8'(i) ^ 8'h5A));
            end
        start_frame(700, 1);
        drive(1'b0, 3000);
        bus.pixel_in_valid = 1'b1;
        wait_done(4000);
        repeat (10) @(posedge clk);
        #1;
        bus.pixel_in_valid = 1'b0;
        end_checks("saturate", 2560, 640);
        chk("saturate ready_cycles", ready_cnt, 640);

        // Reset mid-frame
        clear_stats();
        in_arr = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
        foreach (exp_rst[i]) exp_q.push_back(exp_rst[i]);
        start_frame(4, 4);
        drive(1'b0, 100);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset outputs", int'({bus.pixel_out, bus.pixel_out_valid, bus.processing_done,
                                      bus.pixel_in_ready, bus.busy}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset out_count", out_cnt, 16);
        chk("midreset leftover_expected", exp_q.size(), 0);
        chk("midreset done_pulses", done_cnt, 0);
        chk("midreset busy", int'(bus.busy), 0);

        clear_stats();
        in_arr = '{8'h5C};
        repeat (4) exp_q.push_back(8'h5C);
        start_frame(1, 1);
        drive(1'b0, 20);
        wait_done(50);
        end_checks("after_reset", 4, 1);

        // Start while busy is ignored
        clear_stats();
        in_arr = '{8'd1, 8'd2, 8'd3, 8'd4};
        foreach (exp_busy[i]) exp_q.push_back(exp_busy[i]);
        start_frame(2, 2);
        fork
            drive(1'b0, 100);
            begin
                int n;
                n = 0;
                while (xfer_cnt < 2 && n < 50) begin
                    @(posedge clk);
                    n++;
                end
                repeat (3) @(posedge clk);
                #1;
                bus.start      = 1'b1;
                bus.largura_in = 10'd8;
                @(posedge clk); #1;
                bus.start      = 1'b0;
                bus.largura_in = 10'd2;
            end
        join
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        end_checks("start_busy", 16, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
